// File: rtl/uart_rd_sched.sv
// uart_rd_sched: round-robin scheduler sharing one transmit-buffer read port
// between NCH UART channels. A granted channel gets WORDS fixed-length slots;
// in each slot the shared address holds the word index and the channel's RD
// strobe pulses for RD_LEN clocks starting at slot count RD_START.
//
// state  | meaning
// IDLE   | no grant, waiting for any pending request
// ARB    | pick next pending channel round-robin from ptr
// SLOTS  | granted channel is being read, one word per slot
// DONE   | frame complete, done pulse visible, grant released
module uart_rd_sched #(
  parameter int NCH      = 5,
  parameter int WORDS    = 18,
  parameter int ADR_W    = 5,
  parameter int SLOT     = 64,
  parameter int RD_START = 40,
  parameter int RD_LEN   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCH-1:0]   strob,
  output logic [NCH-1:0]   RD,
  output logic [ADR_W-1:0] RdAdr,
  output logic [NCH-1:0]   gnt,
  output logic             busy,
  output logic [NCH-1:0]   done
);

  localparam int SC_W = (SLOT > 1) ? $clog2(SLOT) : 1;
  localparam int GI_W = $clog2(NCH);

  typedef enum logic [1:0] {S_IDLE, S_ARB, S_SLOTS, S_DONE} state_t;

  state_t            state;
  logic [NCH-1:0]    s1, s2, prev;
  logic [NCH-1:0]    pending;
  logic [NCH-1:0]    pend_set;
  logic [GI_W-1:0]   ptr;
  logic [GI_W-1:0]   g;
  logic [GI_W-1:0]   sel;
  logic [SC_W-1:0]   sc;
  logic [SC_W-1:0]   sc_nxt;
  logic [ADR_W-1:0]  wc;
  logic              rd_on;
  logic              found;
  int                scan_i;

  // Two-flop synchronizer plus one history flop for rising-edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1   <= '0;
      s2   <= '0;
      prev <= '0;
    end else begin
      s1   <= strob;
      s2   <= s1;
      prev <= s2;
    end
  end

  // New requests: synchronized rising edges, except on the channel being served.
  assign pend_set = s2 & ~prev & ~gnt;

  // Round-robin pick: first pending channel at or after ptr.
  always_comb begin
    sel    = ptr;
    found  = 1'b0;
    scan_i = 0;
    for (int k = 0; k < NCH; k++) begin
      scan_i = int'(ptr) + k;
      if (scan_i >= NCH) scan_i = scan_i - NCH;
      if (!found && pending[scan_i]) begin
        found = 1'b1;
        sel   = GI_W'(scan_i);
      end
    end
  end

  // Slot counter look-ahead; RD is registered so it follows the next count.
  always_comb begin
    sc_nxt = (sc == SC_W'(SLOT - 1)) ? '0 : sc + 1'b1;
    rd_on  = (int'(sc_nxt) >= RD_START) && (int'(sc_nxt) < RD_START + RD_LEN);
  end

  // Scheduler FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      pending <= '0;
      ptr     <= '0;
      g       <= '0;
      sc      <= '0;
      wc      <= '0;
      RD      <= '0;
      RdAdr   <= '0;
      gnt     <= '0;
      busy    <= 1'b0;
      done    <= '0;
    end else begin
      done    <= '0;
      pending <= pending | pend_set;
      case (state)
        S_IDLE: begin
          if (|pending) state <= S_ARB;
        end
        S_ARB: begin
          g     <= sel;
          gnt   <= {{(NCH-1){1'b0}}, 1'b1} << sel;
          busy  <= 1'b1;
          sc    <= '0;
          wc    <= '0;
          RdAdr <= '0;
          RD    <= '0;
          state <= S_SLOTS;
        end
        S_SLOTS: begin
          sc <= sc_nxt;
          RD <= rd_on ? gnt : '0;
          if (sc == SC_W'(SLOT - 1)) begin
            if (wc == ADR_W'(WORDS - 1)) begin
              state   <= S_DONE;
              done    <= gnt;
              gnt     <= '0;
              busy    <= 1'b0;
              RdAdr   <= '0;
              RD      <= '0;
              pending <= (pending | pend_set) & ~gnt;
              ptr     <= (g == GI_W'(NCH - 1)) ? '0 : g + 1'b1;
            end else begin
              wc    <= wc + 1'b1;
              RdAdr <= wc + 1'b1;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
